// File: rtl/am_demod.sv
// -----------------------------------------------------------------------------
// am_demod -- envelope-detecting AM demodulator
//
// Receive-side partner of am_out. Each accepted 8-bit offset-binary sample is
// full-wave rectified about midscale into a 7-bit magnitude. The magnitudes are
// peak-held over a window of WIN accepted samples, which is one carrier period.
// At the end of each window the peak becomes the envelope sample and is flagged
// with a one-cycle valid strobe. The same peak also drives a carrier-presence
// FSM with hysteresis.
//
// Optional build macro:
//   AM_DEMOD_SMOOTH_EN  when defined, the envelope output is a first-order IIR
//                       of the window peaks: env += (peak - env) >>> 2.
//                       When undefined, the envelope output is the window peak.
//                       In both builds the FSM uses the raw window peak.
//
// Parameters:
//   WIN       samples per peak-hold window (power of two, >= 4)
//   THRESH    minimum window peak that counts as carrier present
//   LOCK_CNT  consecutive qualifying windows needed to enter or leave lock (>= 1)
//
// Ports:
//   clk         in   1  system clock; all logic on the rising edge
//   rst         in   1  synchronous, active-high reset
//   am_wave     in   8  AM sample, offset binary (128 = zero level)
//   sample_en   in   1  qualifies am_wave for the current edge
//   envelope    out  7  recovered envelope magnitude, 0..127
//   env_valid   out  1  one-cycle pulse when envelope updates
//   carrier_ok  out  1  high while the FSM is in LOCKED
// -----------------------------------------------------------------------------
module am_demod #(
  parameter int WIN      = 32,
  parameter int THRESH   = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] am_wave,
  input  logic       sample_en,
  output logic [6:0] envelope,
  output logic       env_valid,
  output logic       carrier_ok
);

  localparam int CW = $clog2(WIN);
  // The lock counter never has to hold LOCK_CNT itself: the LOCK_CNT-th hit
  // switches state and clears it.
  localparam int LW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);

  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);
  localparam logic [6:0]    THRESH_M  = 7'(THRESH);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // ---------------------------------------------------------------------------
  // Stage 1: rectify and register
  // ---------------------------------------------------------------------------
  logic [6:0] w_mag;
  logic [6:0] r_mag;
  logic       r_mag_v;

  // Above midscale the magnitude is am_wave-128, i.e. the low seven bits.
  // Below midscale it is 127-am_wave, which is the bitwise inverse of those
  // seven bits. Both are exact in 0..127.
  assign w_mag = am_wave[7] ? am_wave[6:0] : ~am_wave[6:0];

  // NOTE: r_mag is pure datapath and is only consumed when r_mag_v is high,
  // so it carries no reset; only the qualifier and control state are reset.
  always_ff @(posedge clk) begin
    if (sample_en) begin
      r_mag <= w_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_v <= 1'b0;
    end else begin
      r_mag_v <= sample_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: peak hold over WIN accepted samples
  // ---------------------------------------------------------------------------
  logic [6:0]    r_peak;
  logic [CW-1:0] r_win_cnt;
  logic [6:0]    w_wpeak;
  logic          w_win_end;

  assign w_wpeak   = (r_mag > r_peak) ? r_mag : r_peak;
  assign w_win_end = r_mag_v && (r_win_cnt == WIN_LAST);

  // ---------------------------------------------------------------------------
  // Envelope update value
  // ---------------------------------------------------------------------------
  logic [6:0] w_env_next;

`ifdef AM_DEMOD_SMOOTH_EN
  logic signed [7:0] w_diff;
  logic signed [7:0] w_step;
  logic        [7:0] w_sum;

  // Both operands are 0..127, so the 8-bit signed difference cannot overflow.
  // The arithmetic shift floors, so the step never overshoots the new peak and
  // the sum stays inside 0..127.
  assign w_diff     = $signed({1'b0, w_wpeak}) - $signed({1'b0, r_envelope_q()});
  assign w_step     = w_diff >>> 2;
  assign w_sum      = {1'b0, envelope} + $unsigned(w_step);
  assign w_env_next = w_sum[6:0];

  function automatic logic [6:0] r_envelope_q();
    return envelope;
  endfunction
`else
  assign w_env_next = w_wpeak;
`endif

  // ---------------------------------------------------------------------------
  // Carrier-presence FSM, evaluated only at window end
  // ---------------------------------------------------------------------------
  logic [0:0]    r_state;
  logic [LW-1:0] r_lock_cnt;
  logic [0:0]    w_state_nxt;
  logic [LW-1:0] w_lock_cnt_nxt;
  logic          w_qual;
  logic          w_hit;

  assign w_qual = (w_wpeak >= THRESH_M);
  // A "hit" is a window that argues for leaving the current state: a strong
  // window while searching, a weak window while locked.
  assign w_hit  = (r_state == ST_SEARCH) ? w_qual : !w_qual;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_win_end) begin
      if (!w_hit) begin
        w_lock_cnt_nxt = '0;
      end else if (r_lock_cnt == LOCK_LAST) begin
        w_state_nxt    = (r_state == ST_SEARCH) ? ST_LOCKED : ST_SEARCH;
        w_lock_cnt_nxt = '0;
      end else begin
        w_lock_cnt_nxt = r_lock_cnt + LW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [6:0] r_envelope;
  logic       r_env_valid;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak      <= '0;
      r_win_cnt   <= '0;
      r_envelope  <= '0;
      r_env_valid <= 1'b0;
      r_state     <= ST_SEARCH;
      r_lock_cnt  <= '0;
    end else begin
      r_env_valid <= w_win_end;
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      if (r_mag_v) begin
        if (w_win_end) begin
          r_envelope <= w_env_next;
          r_peak     <= '0;
          r_win_cnt  <= '0;
        end else begin
          r_peak     <= w_wpeak;
          r_win_cnt  <= r_win_cnt + CW'(1);
        end
      end
    end
  end

  assign envelope   = r_envelope;
  assign env_valid  = r_env_valid;
  assign carrier_ok = (r_state == ST_LOCKED);

endmodule
